// File: rtl/voice_scheduler_pkg.sv
// rtl/voice_scheduler_pkg.sv - shared types and constants for the voice scheduler
//
// Purpose: allocator FSM state encoding, default widths, beat rate.
// Ports:   none (package).
package voice_scheduler_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ALLOC = 1'b1
    } sched_state_t;

    localparam int NUM_VOICES_DEFAULT = 3;
    localparam int NOTE_W_DEFAULT     = 6;
    localparam int DUR_W_DEFAULT      = 6;

    // Duration counters tick once per beat; beats arrive at this rate.
    localparam int BEAT_RATE_HZ       = 48;

endpackage

// File: rtl/voice_scheduler_counter.sv
// rtl/voice_scheduler_counter.sv - per-voice remaining-duration down counter
//
// Purpose: holds one voice's remaining beats; load beats decrement.
// Ports:
//   i_clk        system clock
//   i_reset      synchronous active-high reset
//   i_load       one-cycle load strobe (wins over i_dec)
//   i_load_val   duration loaded unmodified
//   i_dec        decrement request (beat qualified by play enable)
//   o_remaining  registered remaining beats
//   o_busy       remaining != 0
module voice_counter #(
    parameter int DUR_W = 6
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [DUR_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [DUR_W-1:0] o_remaining,
    output logic             o_busy
);

    logic [DUR_W-1:0] r_remaining;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_remaining <= '0;
        end else if (i_load) begin
            r_remaining <= i_load_val;
        end else if (i_dec && (r_remaining != '0)) begin
            // Saturates at zero: an idle voice ignores beats.
            r_remaining <= r_remaining - DUR_W'(1);
        end
    end

    assign o_remaining = r_remaining;
    assign o_busy      = (r_remaining != '0);

endmodule

// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - handshaked note-event to voice allocator
//
// Purpose: accepts note events, assigns each to the lowest-index free voice,
//          issues a one-cycle one-hot load pulse and tracks per-voice durations.
// Optional feature macro: VOICE_STEAL_EN (steal the voice with the least
//          remaining duration instead of waiting when all voices are busy).
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_play_enable        run / freeze counters and allocation
//   i_beat               one-cycle beat tick
//   i_ev_valid/o_ev_ready  event handshake; i_ev_note, i_ev_duration payload
//   o_voice_load         one-hot one-cycle load pulse
//   o_voice_note         note for the pulsed voice
//   o_voice_busy         per-voice remaining != 0
//   o_all_idle           no voice busy and allocator idle
//   o_stall              held event waiting for a free voice
module voice_scheduler
    import voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEFAULT,
    parameter int NOTE_W     = NOTE_W_DEFAULT,
    parameter int DUR_W      = DUR_W_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_play_enable,
    input  logic                  i_beat,
    input  logic                  i_ev_valid,
    input  logic [NOTE_W-1:0]     i_ev_note,
    input  logic [DUR_W-1:0]      i_ev_duration,
    output logic                  o_ev_ready,
    output logic [NUM_VOICES-1:0] o_voice_load,
    output logic [NOTE_W-1:0]     o_voice_note,
    output logic [NUM_VOICES-1:0] o_voice_busy,
    output logic                  o_all_idle,
    output logic                  o_stall
);

    sched_state_t          r_state;
    logic [NOTE_W-1:0]     r_hold_note;
    logic [DUR_W-1:0]      r_hold_dur;
    logic [NUM_VOICES-1:0] r_voice_load;
    logic [NOTE_W-1:0]     r_voice_note;
    logic                  r_stall;

    logic [DUR_W-1:0]      w_remaining [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_busy;
    logic [NUM_VOICES-1:0] w_free;
    logic [NUM_VOICES-1:0] w_lowest_free;
    logic [NUM_VOICES-1:0] w_load_vec;
    logic                  w_ev_ready;
    logic                  w_dec;
    logic                  w_alloc_go;

    assign w_ev_ready = i_play_enable && !i_reset && (r_state == S_IDLE);
    assign w_dec      = i_beat && i_play_enable;

    // A zero-duration event is dropped in ALLOC rather than loaded.
    assign w_alloc_go = (r_state == S_ALLOC) && i_play_enable && (r_hold_dur != '0);

    genvar g;
    generate
        for (g = 0; g < NUM_VOICES; g++) begin : g_voice
            voice_counter #(.DUR_W(DUR_W)) u_counter (
                .i_clk       (i_clk),
                .i_reset     (i_reset),
                .i_load      (w_load_vec[g]),
                .i_load_val  (r_hold_dur),
                .i_dec       (w_dec),
                .o_remaining (w_remaining[g]),
                .o_busy      (w_busy[g])
            );
            // Freedom is judged on the registered count, so a voice that
            // reaches zero on this edge is only reusable from the next cycle.
            assign w_free[g] = (w_remaining[g] == '0);
        end
    endgenerate

    // Isolate the lowest set bit of the free mask.
    assign w_lowest_free = w_free & (~w_free + NUM_VOICES'(1));

`ifdef VOICE_STEAL_EN
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [IDX_W-1:0] w_steal_idx;
    logic [DUR_W-1:0] w_steal_min;

    // Smallest remaining wins; strict compare keeps the lowest index on ties.
    // Only consulted when every voice is busy, so all candidates are nonzero.
    always_comb begin
        w_steal_idx = '0;
        w_steal_min = w_remaining[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (w_remaining[v] < w_steal_min) begin
                w_steal_min = w_remaining[v];
                w_steal_idx = IDX_W'(v);
            end
        end
    end

    always_comb begin
        w_load_vec = '0;
        if (w_alloc_go) begin
            if (|w_free) begin
                w_load_vec = w_lowest_free;
            end else begin
                w_load_vec = NUM_VOICES'(1) << w_steal_idx;
            end
        end
    end
`else
    always_comb begin
        w_load_vec = '0;
        if (w_alloc_go && (|w_free)) begin
            w_load_vec = w_lowest_free;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_hold_note  <= '0;
            r_hold_dur   <= '0;
            r_voice_load <= '0;
            r_voice_note <= '0;
            r_stall      <= 1'b0;
        end else begin
            // The counter load and the visible pulse share this edge.
            r_voice_load <= w_load_vec;
            if (|w_load_vec) begin
                r_voice_note <= r_hold_note;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_ev_valid && w_ev_ready) begin
                        r_hold_note <= i_ev_note;
                        r_hold_dur  <= i_ev_duration;
                        r_state     <= S_ALLOC;
                    end
                end
                S_ALLOC: begin
                    // With play disabled the held event simply waits here.
                    if (i_play_enable) begin
                        if ((r_hold_dur == '0) || (|w_load_vec)) begin
                            r_state <= S_IDLE;
                            r_stall <= 1'b0;
                        end else begin
                            r_stall <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ev_ready   = w_ev_ready;
    assign o_voice_load = r_voice_load;
    assign o_voice_note = r_voice_note;
    assign o_voice_busy = w_busy;
    assign o_all_idle   = (w_busy == '0) && (r_state == S_IDLE);
    assign o_stall      = r_stall;

endmodule

// File: tb/tb_voice_scheduler.sv
// tb/tb_voice_scheduler.sv - directed self-checking bench for voice_scheduler
module tb_voice_scheduler;

    logic       clk;
    logic       reset;
    logic       play_enable;
    logic       beat;
    logic       ev_valid;
    logic [5:0] ev_note;
    logic [5:0] ev_duration;
    logic       ev_ready;
    logic [2:0] voice_load;
    logic [5:0] voice_note;
    logic [2:0] voice_busy;
    logic       all_idle;
    logic       stall;

    int n_tests = 0;
    int n_fail  = 0;

    voice_scheduler #(
        .NUM_VOICES (3),
        .NOTE_W     (6),
        .DUR_W      (6)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_play_enable (play_enable),
        .i_beat        (beat),
        .i_ev_valid    (ev_valid),
        .i_ev_note     (ev_note),
        .i_ev_duration (ev_duration),
        .o_ev_ready    (ev_ready),
        .o_voice_load  (voice_load),
        .o_voice_note  (voice_note),
        .o_voice_busy  (voice_busy),
        .o_all_idle    (all_idle),
        .o_stall       (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            beat = 1'b1;
            step();
        end
        beat = 1'b0;
    endtask

    // Waits (bounded) for ready, then offers one event for one cycle.
    task automatic send(input logic [5:0] note, input logic [5:0] dur);
        int w;
        w = 0;
        while ((ev_ready !== 1'b1) && (w < 50)) begin
            step();
            w++;
        end
        chk("send_ready", {31'd0, ev_ready}, 32'd1);
        ev_valid    = 1'b1;
        ev_note     = note;
        ev_duration = dur;
        step();
        ev_valid    = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        play_enable = 1'b0;
        beat        = 1'b0;
        ev_valid    = 1'b0;
        ev_note     = '0;
        ev_duration = '0;
        step();
        play_enable = 1'b1;
        // Reset cycle: ready must be low even with play enabled.
        chk("rst_ready", {31'd0, ev_ready}, 32'd0);
        chk("rst_load", {29'd0, voice_load}, 32'd0);
        chk("rst_note", {26'd0, voice_note}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy", {29'd0, voice_busy}, 32'd0);
        chk("rst_idle", {31'd0, all_idle}, 32'd1);
        reset = 1'b0;
        step();
        chk("post_rst_ready", {31'd0, ev_ready}, 32'd1);

        // Single event, note 20 dur 4.
        send(6'd20, 6'd4);
        chk("t1_alloc_ready", {31'd0, ev_ready}, 32'd0);
        chk("t1_alloc_load", {29'd0, voice_load}, 32'd0);
        step();
        chk("t1_load", {29'd0, voice_load}, 32'd1);
        chk("t1_note", {26'd0, voice_note}, 32'd20);
        chk("t1_busy", {29'd0, voice_busy}, 32'd1);
        chk("t1_ready_back", {31'd0, ev_ready}, 32'd1);
        chk("t1_not_idle", {31'd0, all_idle}, 32'd0);
        step();
        chk("t1_pulse_one_cycle", {29'd0, voice_load}, 32'd0);
        beats(3);
        chk("t1_busy_after3", {29'd0, voice_busy}, 32'd1);
        beats(1);
        chk("t1_busy_after4", {29'd0, voice_busy}, 32'd0);
        chk("t1_idle_after4", {31'd0, all_idle}, 32'd1);

        // Three back-to-back events fill voices 0, 1, 2.
        send(6'd1, 6'd10);
        step();
        chk("t2_load_v0", {29'd0, voice_load}, 32'd1);
        send(6'd2, 6'd10);
        step();
        chk("t2_load_v1", {29'd0, voice_load}, 32'd2);
        chk("t2_note_v1", {26'd0, voice_note}, 32'd2);
        send(6'd3, 6'd10);
        step();
        chk("t2_load_v2", {29'd0, voice_load}, 32'd4);
        chk("t2_busy_all", {29'd0, voice_busy}, 32'd7);
        chk("t2_not_idle", {31'd0, all_idle}, 32'd0);

`ifdef VOICE_STEAL_EN
        // All remaining equal: tie goes to voice 0, no stall.
        send(6'd4, 6'd5);
        chk("t3s_stall_alloc", {31'd0, stall}, 32'd0);
        step();
        chk("t3s_load_tie", {29'd0, voice_load}, 32'd1);
        chk("t3s_note_tie", {26'd0, voice_note}, 32'd4);
        chk("t3s_stall_after", {31'd0, stall}, 32'd0);
        beats(10);
        chk("t3s_drained", {29'd0, voice_busy}, 32'd0);
        send(6'd1, 6'd5);
        step();
        send(6'd2, 6'd2);
        step();
        send(6'd3, 6'd7);
        step();
        chk("t3s_busy_all", {29'd0, voice_busy}, 32'd7);
        // remaining {5,2,7}: voice 1 is stolen.
        send(6'd9, 6'd3);
        chk("t3s_stall_alloc2", {31'd0, stall}, 32'd0);
        step();
        chk("t3s_load_min", {29'd0, voice_load}, 32'd2);
        chk("t3s_note_min", {26'd0, voice_note}, 32'd9);
        chk("t3s_stall_after2", {31'd0, stall}, 32'd0);
        beats(2);
        chk("t3s_reloaded", {29'd0, voice_busy}, 32'd7);
        beats(1);
        chk("t3s_v1_done", {29'd0, voice_busy}, 32'd5);
`else
        // Fourth event while all busy waits for a free voice.
        send(6'd4, 6'd5);
        step();
        chk("t3_stall", {31'd0, stall}, 32'd1);
        chk("t3_stall_ready", {31'd0, ev_ready}, 32'd0);
        chk("t3_stall_noload", {29'd0, voice_load}, 32'd0);
        beats(9);
        chk("t3_stall_9", {31'd0, stall}, 32'd1);
        chk("t3_busy_9", {29'd0, voice_busy}, 32'd7);
        beats(1);
        chk("t3_freed", {29'd0, voice_busy}, 32'd0);
        chk("t3_no_same_cycle", {29'd0, voice_load}, 32'd0);
        chk("t3_stall_10", {31'd0, stall}, 32'd1);
        step();
        chk("t3_load", {29'd0, voice_load}, 32'd1);
        chk("t3_note", {26'd0, voice_note}, 32'd4);
        chk("t3_stall_clr", {31'd0, stall}, 32'd0);
        chk("t3_ready", {31'd0, ev_ready}, 32'd1);
`endif
        beats(12);
        chk("drain_idle", {31'd0, all_idle}, 32'd1);

        // Zero-duration event is accepted and dropped.
        send(6'd7, 6'd0);
        chk("t4_alloc_ready", {31'd0, ev_ready}, 32'd0);
        step();
        chk("t4_noload", {29'd0, voice_load}, 32'd0);
        chk("t4_ready", {31'd0, ev_ready}, 32'd1);
        chk("t4_idle", {31'd0, all_idle}, 32'd1);

        // Beat coincident with load: load value kept.
        send(6'd8, 6'd3);
        beat = 1'b1;
        step();
        beat = 1'b0;
        chk("t5_load", {29'd0, voice_load}, 32'd1);
        beats(2);
        chk("t5_busy_2", {29'd0, voice_busy}, 32'd1);
        beats(1);
        chk("t5_busy_3", {29'd0, voice_busy}, 32'd0);

        // play_enable dropped mid-ALLOC.
        send(6'd10, 6'd4);
        step();
        chk("t6_load_v0", {29'd0, voice_load}, 32'd1);
        send(6'd11, 6'd6);
        play_enable = 1'b0;
        beat        = 1'b1;
        step();
        chk("t6_frozen_load", {29'd0, voice_load}, 32'd0);
        chk("t6_frozen_ready", {31'd0, ev_ready}, 32'd0);
        step();
        chk("t6_frozen_load2", {29'd0, voice_load}, 32'd0);
        chk("t6_frozen_busy", {29'd0, voice_busy}, 32'd1);
        beat        = 1'b0;
        play_enable = 1'b1;
        step();
        chk("t6_resume_load", {29'd0, voice_load}, 32'd2);
        chk("t6_resume_note", {26'd0, voice_note}, 32'd11);
        beats(3);
        chk("t6_counters_held", {29'd0, voice_busy}, 32'd3);
        beats(1);
        chk("t6_v0_done", {29'd0, voice_busy}, 32'd2);

        // Reset mid-ALLOC discards the held event and clears counters.
        send(6'd12, 6'd5);
        reset = 1'b1;
        step();
        chk("t7_busy", {29'd0, voice_busy}, 32'd0);
        chk("t7_load", {29'd0, voice_load}, 32'd0);
        chk("t7_idle", {31'd0, all_idle}, 32'd1);
        chk("t7_ready_in_rst", {31'd0, ev_ready}, 32'd0);
        reset = 1'b0;
        step();
        chk("t7_ready", {31'd0, ev_ready}, 32'd1);
        chk("t7_discard", {29'd0, voice_load}, 32'd0);
        step();
        chk("t7_discard2", {29'd0, voice_load}, 32'd0);
        chk("t7_stall", {31'd0, stall}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/voice_scheduler.md
Name: voice_scheduler

Overview:
- Allocates incoming note events to a pool of NUM_VOICES note-player voices.
- Owns each voice's per-voice duration counter, which counts down on the 1/48 s beat.
- Issues one-cycle load pulses and tracks which voices are busy.
- Sits between the song/note sequencer and the harmonic chord player datapath, replacing ad-hoc slot selection with a registered, handshaked allocator.

Parameters:
- NUM_VOICES, 3, number of voices managed (1..8)
- NOTE_W, 6, note code width
- DUR_W, 6, duration width in beats

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- play_enable  in  1  high = run; low = freeze counters, block allocation
- beat  in  1  one-cycle 48 Hz tick
- ev_valid  in  1  note event offered
- ev_note  in  NOTE_W  note code of event
- ev_duration  in  DUR_W  event length in beats
- ev_ready  out  1  scheduler accepts event this cycle
- voice_load  out  NUM_VOICES  one-hot, one-cycle load pulse to target voice
- voice_note  out  NOTE_W  note for pulsed voice; valid only while voice_load != 0
- voice_busy  out  NUM_VOICES  bit v = remaining[v] != 0
- all_idle  out  1  no voice busy and FSM in IDLE
- stall  out  1  held event waiting for a free voice

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset state:
  - all remaining counters 0; FSM IDLE; holding registers 0.
  - voice_load 0, voice_note 0, stall 0, voice_busy 0, all_idle 1.
  - ev_ready 0 during the reset cycle.
- ev_ready = play_enable && !reset && state==IDLE (combinational from state).
- Accept: ev_valid && ev_ready. Latch ev_note and ev_duration into hold_note/hold_dur, then go to ALLOC.
- Zero-duration event: accepted, then dropped in ALLOC. No load pulse; FSM returns to IDLE.
- ALLOC state, evaluated each cycle while play_enable is high:
  - If any voice is free (remaining==0 as registered), pick the lowest-index free voice v.
  - Register voice_load=onehot(v) and voice_note=hold_note. The pulse appears the cycle after ALLOC is evaluated.
  - Set remaining[v]=hold_dur in the same edge; return to IDLE.
  - If no voice is free: stay in ALLOC with stall=1 (WAIT behaviour).
- Latency: accept at edge N → voice_load visible in cycle N+1 at the earliest → ev_ready high again in cycle N+1.
- Counters:
  - On beat && play_enable, every nonzero remaining[v] decrements by 1.
  - A counter that reaches 0 makes its voice free from the next cycle; there is no same-cycle reuse.
  - Counters saturate at 0 and never wrap.
- Load vs beat: if a load and a beat hit the same voice in the same cycle, the load wins; the beat is ignored for that voice.
- play_enable low:
  - counters hold; ALLOC does not allocate; voice_load forced 0.
  - a held event is retained and resumes when play_enable returns high.
- Reset mid-ALLOC: the held event is discarded and all counters are cleared.
- voice_load is never multi-hot. At most one load per cycle.
- Width rule: remaining is DUR_W bits; ev_duration is loaded unmodified.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined: in ALLOC with no free voice, steal the voice with the smallest nonzero remaining (ties → lowest index).
  - Reload that voice immediately, in the same cycle as entering the check.
  - stall never asserts.
- Undefined: wait-for-free behaviour as above; stall asserts while waiting.

Decomposition:
- Shared package (e.g. synth_pkg):
  - FSM state encoding (IDLE, ALLOC).
  - Default NOTE_W/DUR_W constants.
  - Beat-rate constant.
- Natural sub-module: voice_counter, one instance per voice.
  - Inputs: clk, reset, load, load_val, dec (= beat && play_enable).
  - Outputs: remaining, busy.
  - Load has priority over dec.
- Selection logic (lowest-free, min-remaining) stays in voice_scheduler.

Test Plan:
- Reset then play_enable=1; offer note 6'd20 dur 4 → voice_load=3'b001 one cycle later, voice_note=20; voice_busy[0] clears 4 beats later.
- Three events back-to-back (durs 10, 10, 10) → loads to voices 0, 1, 2 in order; all_idle=0.
- Fourth event while all busy, no VOICE_STEAL_EN → stall=1 and ev_ready=0 until the first beat zeroes a counter; that voice is loaded the next cycle.
- Same as above with VOICE_STEAL_EN, remaining = {5, 2, 7} → voice 1 is reloaded immediately; stall stays 0.
- Event with dur 0 → accepted; no voice_load; ev_ready returns high the next cycle.
- beat coincident with the load of voice 0 (dur 3) → remaining[0]=3, not 2. play_enable dropped mid-ALLOC → no load until re-enabled; counters frozen.
